// File: rtl/keccak_pack.sv
// keccak_pack: packs 16 cust5 words into a 512-bit block with valid/ready handoff; define KECCAK_PACK_INDEXED_EN for indexed fill
module keccak_pack #(
    parameter int WORDS = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [5:0]               num,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WORDS*WIDTH-1:0]   out512,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    output logic                     busy,
    output logic [4:0]               wcnt,
    output logic                     overrun
);
    typedef enum logic {FILL, FULL} state_t;
    state_t state, state_n;
    logic wr, clr, last;
    logic [3:0] sel;
    logic [4:0] cnt, cnt_n;
    assign wr  = en && !num[5];
    assign clr = en && num[5];
`ifdef KECCAK_PACK_INDEXED_EN
    logic [WORDS-1:0] mask, mask_n;
    logic unused_num;
    assign unused_num = num[4];
    assign sel    = num[3:0];
    assign mask_n = mask | (WORDS'(1) << sel);
    assign last   = &mask_n;
    assign cnt_n  = cnt + {4'd0, ~mask[sel]};
`else
    logic [3:0] ptr;
    logic [4:0] unused_num;
    assign unused_num = num[4:0];
    assign sel   = ptr;
    assign last  = cnt == 5'd15;
    assign cnt_n = cnt + 5'd1;
`endif
    assign blk_valid = state == FULL;
    assign busy      = blk_valid;
    assign wcnt      = cnt;
    // state register
    always_ff @(posedge clk)
        state <= rst ? FILL : state_n;
    // next state: clear wins, a completing write fills, a handshake drains
    always_comb begin
        state_n = state;
        state_n = clr ? FILL :
                  (state == FILL) ? ((wr && last) ? FULL : FILL) :
                  (blk_ready ? FILL : FULL);
    end
    // datapath: capture words while filling, flag drops and release on handshake while full
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            out512  <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
`ifdef KECCAK_PACK_INDEXED_EN
            mask    <= '0;
`else
            ptr     <= '0;
`endif
        end else if (state == FILL) begin
            if (wr) begin
                out512[sel*WIDTH +: WIDTH] <= wdata;
                cnt <= cnt_n;
`ifdef KECCAK_PACK_INDEXED_EN
                mask <= mask_n;
`else
                ptr <= ptr + 4'd1;
`endif
            end
        end else begin
            if (wr)
                overrun <= 1'b1;
            if (blk_ready) begin
                cnt <= '0;
`ifdef KECCAK_PACK_INDEXED_EN
                mask <= '0;
`else
                ptr <= '0;
`endif
            end
        end
    end
endmodule
